// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and constants for the hardwired control sequencer
//   state_t      : sequencer states (STEP only reachable with CTRL_SEQ_SINGLE_STEP_EN)
//   CLS_*        : instruction class codes from ir[OPC_W-1:OPC_W-4]
//   MUXB_*       : bus B source selects
//   ALU_PASS_DEF : default ALU code that passes bus A straight through
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, F1, F2, F3, DEC, EXEC, MWAIT, WB, HALT, STEP
    } state_t;

    localparam logic [3:0] CLS_NOP  = 4'd0;
    localparam logic [3:0] CLS_LDAC = 4'd1;
    localparam logic [3:0] CLS_STAC = 4'd2;
    localparam logic [3:0] CLS_MVR  = 4'd3;
    localparam logic [3:0] CLS_MVA  = 4'd4;
    localparam logic [3:0] CLS_ALU  = 4'd5;
    localparam logic [3:0] CLS_JMP  = 4'd6;
    localparam logic [3:0] CLS_JMPZ = 4'd7;
    localparam logic [3:0] CLS_JMPN = 4'd8;
    localparam logic [3:0] CLS_HALT = 4'd15;

    localparam logic [1:0] MUXB_MDR = 2'd0;
    localparam logic [1:0] MUXB_AC  = 2'd1;
    localparam logic [1:0] MUXB_TR  = 2'd2;

    localparam logic [3:0] ALU_PASS_DEF = 4'b1001;

endpackage

// File: rtl/ctrl_seq_wait_tmr.sv
// ctrl_seq_wait_tmr: loadable down-counter timing the DRAM read latency
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   load       : load MEM_LAT-1
//   dec        : count down by one (saturates at zero)
//   done       : count has reached its last waiting cycle
module ctrl_seq_wait_tmr #(
    parameter int MEM_LAT = 2,
    localparam int W = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load)
            r_cnt <= W'(MEM_LAT - 1);
        else if (dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // the cycle holding a count of one is the final wait cycle
    assign done = r_cnt <= W'(1);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: hardwired fetch/decode/execute sequencer driving the datapath strobes
//   Optional macro CTRL_SEQ_SINGLE_STEP_EN adds input step and a STEP pause state.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : leave IDLE and begin fetching
//   ir, tr, z, neg       : instruction, operand and ALU flags from the datapath
//   inc_pc .. write_tr   : fetch strobes
//   write_mar .. mdr     : memory strobes
//   select_mux_a/b       : bus A / bus B sources
//   alu_sel, write_ac    : ALU operation, AC write enable
//   write_reg            : one-hot general register write enables
//   busy, halted, illegal: status (illegal is sticky until reset)
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int OPC_W   = 8,
    parameter int NREG    = 8,
    parameter int MUXA_W  = 4,
    parameter int ALU_W   = 4,
    parameter int MEM_LAT = 2,
    parameter logic [ALU_W-1:0] ALU_PASS = ALU_W'(ALU_PASS_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [OPC_W-1:0]  ir,
    input  logic [17:0]       tr,
    input  logic              z,
    input  logic              neg,
    output logic              inc_pc,
    output logic              write_pc,
    output logic              write_iar,
    output logic              write_idr,
    output logic              write_ir,
    output logic              write_tr,
    output logic              write_mar,
    output logic              write_dram,
    output logic              write1_mdr,
    output logic              write2_mdr,
    output logic [MUXA_W-1:0] select_mux_a,
    output logic [1:0]        select_mux_b,
    output logic [ALU_W-1:0]  alu_sel,
    output logic              write_ac,
    output logic [NREG-1:0]   write_reg,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int IW = OPC_W - 4;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
    localparam state_t RET = STEP;
`else
    localparam state_t RET = F1;
`endif

    state_t          r_state, w_next;
    logic [3:0]      r_cls;
    logic [IW-1:0]   r_idx;
    logic            r_illegal;
    logic            w_idx_ok, w_bad, w_done;
    logic [NREG-1:0] w_onehot;
    logic            w_unused;

    assign w_unused = ^tr[17:ALU_W];
    assign w_idx_ok = 32'(r_idx) < NREG;
    assign w_onehot = NREG'(1) << r_idx;
    // classes 9-14 are undefined; MVR/MVA also reject registers that do not exist
    assign w_bad    = (r_cls > CLS_JMPN && r_cls != CLS_HALT) ||
                      ((r_cls == CLS_MVR || r_cls == CLS_MVA) && !w_idx_ok);

    ctrl_seq_wait_tmr #(.MEM_LAT(MEM_LAT)) u_tmr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (r_state == EXEC),
        .dec  (r_state == MWAIT),
        .done (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cls     <= '0;
            r_idx     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DEC) begin
                r_cls <= ir[OPC_W-1:OPC_W-4];
                r_idx <= ir[IW-1:0];
            end
            if (r_state == EXEC && w_bad)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = start ? F1 : IDLE;
            F1:    w_next = F2;
            F2:    w_next = F3;
            F3:    w_next = DEC;
            DEC:   w_next = EXEC;
            EXEC:  w_next = (w_bad || r_cls == CLS_HALT) ? HALT :
                            r_cls == CLS_LDAC ? (MEM_LAT > 1 ? MWAIT : WB) :
                            r_cls == CLS_STAC ? WB : RET;
            MWAIT: w_next = w_done ? WB : MWAIT;
            WB:    w_next = RET;
            HALT:  w_next = HALT;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
            STEP:  w_next = step ? F1 : STEP;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        inc_pc       = 1'b0;
        write_pc     = 1'b0;
        write_iar    = 1'b0;
        write_idr    = 1'b0;
        write_ir     = 1'b0;
        write_tr     = 1'b0;
        write_mar    = 1'b0;
        write_dram   = 1'b0;
        write1_mdr   = 1'b0;
        write2_mdr   = 1'b0;
        select_mux_a = '0;
        select_mux_b = MUXB_MDR;
        alu_sel      = ALU_PASS;
        write_ac     = 1'b0;
        write_reg    = '0;
        case (r_state)
            F1: write_iar = 1'b1;
            F2: begin
                write_idr = 1'b1;
                inc_pc    = 1'b1;
            end
            F3: begin
                write_ir = 1'b1;
                write_tr = 1'b1;
            end
            EXEC: case (r_cls)
                CLS_LDAC: begin
                    write_mar    = 1'b1;
                    select_mux_b = MUXB_TR;
                end
                CLS_STAC: begin
                    write_mar    = 1'b1;
                    write1_mdr   = 1'b1;
                    select_mux_b = MUXB_AC;
                end
                CLS_MVR: if (w_idx_ok) begin
                    select_mux_b = MUXB_AC;
                    write_reg    = w_onehot;
                end
                CLS_MVA: if (w_idx_ok) begin
                    select_mux_a = MUXA_W'(r_idx);
                    write_ac     = 1'b1;
                end
                CLS_ALU: begin
                    select_mux_a = MUXA_W'(r_idx);
                    select_mux_b = MUXB_AC;
                    alu_sel      = tr[ALU_W-1:0];
                    write_ac     = 1'b1;
                end
                CLS_JMP, CLS_JMPZ, CLS_JMPN: begin
                    select_mux_b = MUXB_TR;
                    write_pc     = r_cls == CLS_JMP || (r_cls == CLS_JMPZ && z) ||
                                   (r_cls == CLS_JMPN && neg);
                end
                default: ;
            endcase
            WB: if (r_cls == CLS_LDAC) begin
                write2_mdr = 1'b1;
                write_ac   = 1'b1;
            end else
                write_dram = 1'b1;
            default: ;
        endcase
    end

    assign busy    = r_state != IDLE && r_state != HALT;
    assign halted  = r_state == HALT;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: randomized self-checking bench for ctrl_seq against a cycle-trace model
module tb_ctrl_seq;

    localparam int MEM_LAT = 2;
    localparam logic [3:0] PASS = 4'b1001;

    typedef struct packed {
        logic       inc_pc, write_pc, write_iar, write_idr, write_ir, write_tr;
        logic       write_mar, write_dram, write1_mdr, write2_mdr;
        logic [3:0] mux_a;
        logic [1:0] mux_b;
        logic [3:0] alu;
        logic       write_ac;
        logic [7:0] wreg;
        logic       busy, halted, illegal;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ir = '0;
    logic [17:0] tr = '0;
    logic        z = 1'b0;
    logic        neg = 1'b0;
    logic        inc_pc, write_pc, write_iar, write_idr, write_ir, write_tr;
    logic        write_mar, write_dram, write1_mdr, write2_mdr;
    logic [3:0]  select_mux_a;
    logic [1:0]  select_mux_b;
    logic [3:0]  alu_sel;
    logic        write_ac;
    logic [7:0]  write_reg;
    logic        busy, halted, illegal;

    outs_t obs;
    outs_t exp_q[$];
    logic  m_ill;
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .tr(tr), .z(z), .neg(neg),
        .inc_pc(inc_pc), .write_pc(write_pc), .write_iar(write_iar), .write_idr(write_idr),
        .write_ir(write_ir), .write_tr(write_tr), .write_mar(write_mar),
        .write_dram(write_dram), .write1_mdr(write1_mdr), .write2_mdr(write2_mdr),
        .select_mux_a(select_mux_a), .select_mux_b(select_mux_b), .alu_sel(alu_sel),
        .write_ac(write_ac), .write_reg(write_reg), .busy(busy), .halted(halted),
        .illegal(illegal)
    );

    assign obs = {inc_pc, write_pc, write_iar, write_idr, write_ir, write_tr,
                  write_mar, write_dram, write1_mdr, write2_mdr, select_mux_a,
                  select_mux_b, alu_sel, write_ac, write_reg, busy, halted, illegal};

    function automatic outs_t quiet(input logic b, input logic h, input logic il);
        outs_t o;
        o = '0;
        o.alu = PASS;
        o.busy = b;
        o.halted = h;
        o.illegal = il;
        return o;
    endfunction

    // expected per-cycle outputs of one instruction, from its first fetch cycle onward
    function automatic void model(input logic [7:0] i_ir, input logic [17:0] i_tr,
                                  input logic i_z, input logic i_n);
        outs_t b, e;
        logic [3:0] c, x;
        logic bad;
        c = i_ir[7:4];
        x = i_ir[3:0];
        b = quiet(1'b1, 1'b0, m_ill);
        e = b; e.write_iar = 1'b1; exp_q.push_back(e);
        e = b; e.write_idr = 1'b1; e.inc_pc = 1'b1; exp_q.push_back(e);
        e = b; e.write_ir = 1'b1; e.write_tr = 1'b1; exp_q.push_back(e);
        exp_q.push_back(b);
        bad = (c >= 9 && c <= 14) || ((c == 3 || c == 4) && x >= 8);
        e = b;
        case (c)
            1: begin e.write_mar = 1'b1; e.mux_b = 2; end
            2: begin e.write_mar = 1'b1; e.write1_mdr = 1'b1; e.mux_b = 1; end
            3: if (!bad) begin e.mux_b = 1; e.wreg = 8'(1) << x; end
            4: if (!bad) begin e.mux_a = x; e.write_ac = 1'b1; end
            5: begin e.mux_a = x; e.mux_b = 1; e.alu = i_tr[3:0]; e.write_ac = 1'b1; end
            6, 7, 8: begin
                e.mux_b = 2;
                e.write_pc = c == 6 || (c == 7 && i_z) || (c == 8 && i_n);
            end
            default: ;
        endcase
        exp_q.push_back(e);
        if (c == 1) begin
            for (int k = 1; k < MEM_LAT; k++) exp_q.push_back(b);
            e = b; e.write2_mdr = 1'b1; e.write_ac = 1'b1; exp_q.push_back(e);
        end
        if (c == 2) begin
            e = b; e.write_dram = 1'b1; exp_q.push_back(e);
        end
        if (bad || c == 15) begin
            m_ill = m_ill | bad;
            exp_q.push_back(quiet(1'b0, 1'b1, m_ill));
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_ill = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== quiet(1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_async: got %h want %h", obs, quiet(1'b0, 1'b0, 1'b0));
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== quiet(1'b0, 1'b0, 1'b0)) begin
                failures++;
                $display("FAIL idle_hold[%0d]: got %h want %h", k, obs, quiet(1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_fetch_nop();
        do_reset();
        start = 1'b1;
        for (int n = 0; n < 2; n++) begin
            ir = 8'h00;
            model(ir, tr, z, neg);
            while (exp_q.size() > 0) begin
                outs_t e;
                @(negedge clk);
                start = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL nop[%0d]: got %h want %h", n, obs, e);
                end
            end
        end
    endtask

    task automatic test_ldac_stac();
        logic [7:0] prog [3] = '{8'h10, 8'h20, 8'h15};
        do_reset();
        start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            ir = prog[n];
            tr = 18'($urandom);
            model(ir, tr, z, neg);
            while (exp_q.size() > 0) begin
                outs_t e;
                @(negedge clk);
                start = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL mem ir=%h: got %h want %h", ir, obs, e);
                end
            end
        end
    endtask

    task automatic test_alu_jumps();
        logic [7:0]  prog [6] = '{8'h53, 8'h70, 8'h70, 8'h60, 8'h80, 8'h80};
        logic [17:0] trs  [6] = '{18'h00002, 18'h100, 18'h100, 18'h7, 18'h3, 18'h3};
        logic        zs   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ns   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        start = 1'b1;
        for (int n = 0; n < 6; n++) begin
            ir = prog[n];
            tr = trs[n];
            z = zs[n];
            neg = ns[n];
            model(ir, tr, z, neg);
            while (exp_q.size() > 0) begin
                outs_t e;
                @(negedge clk);
                start = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL alu_jmp ir=%h z=%b n=%b: got %h want %h", ir, z, neg, obs, e);
                end
            end
        end
    endtask

    task automatic test_random_back_to_back();
        do_reset();
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 8));
            ir = {c, (c == 3 || c == 4) ? 4'($urandom_range(0, 7)) : 4'($urandom)};
            tr = 18'($urandom);
            z = 1'($urandom);
            neg = 1'($urandom);
            model(ir, tr, z, neg);
            while (exp_q.size() > 0) begin
                outs_t e;
                @(negedge clk);
                start = 1'($urandom);
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL rand ir=%h tr=%h: got %h want %h", ir, tr, obs, e);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_illegal_halt();
        logic [7:0] prog [4] = '{8'hA0, 8'h39, 8'h4F, 8'hF0};
        for (int n = 0; n < 4; n++) begin
            do_reset();
            start = 1'b1;
            ir = prog[n];
            model(ir, tr, z, neg);
            while (exp_q.size() > 0) begin
                outs_t e;
                @(negedge clk);
                start = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL halt ir=%h: got %h want %h", ir, obs, e);
                end
            end
            start = 1'b1;
            ir = 8'h00;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (obs !== quiet(1'b0, 1'b1, prog[n][7:4] != 4'hF)) begin
                    failures++;
                    $display("FAIL halt_sticky ir=%h: got %h want %h", prog[n], obs,
                             quiet(1'b0, 1'b1, prog[n][7:4] != 4'hF));
                end
            end
            rst_n = 1'b0;
            #1;
            checks++;
            if (obs !== quiet(1'b0, 1'b0, 1'b0)) begin
                failures++;
                $display("FAIL halt_reset: got %h want %h", obs, quiet(1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_reset_in_mwait();
        do_reset();
        start = 1'b1;
        ir = 8'h10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== quiet(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL mwait_state: got %h want %h", obs, quiet(1'b1, 1'b0, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== quiet(1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL mwait_abort: got %h want %h", obs, quiet(1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== quiet(1'b0, 1'b0, 1'b0)) begin
                failures++;
                $display("FAIL mwait_release[%0d]: got %h want %h", k, obs, quiet(1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    initial begin
        m_ill = 1'b0;
        test_reset();
        test_fetch_nop();
        test_ldac_stac();
        test_alu_jumps();
        test_random_back_to_back();
        test_illegal_halt();
        test_reset_in_mwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
